// File: rtl/msg_field_extract_mc.sv
// rtl/msg_field_extract_mc.sv - multi-channel market-data header check, type decode and round-robin serialiser

// Per-channel message queue: registered storage, read data valid while not empty.
module msg_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    // Next storage and pointer values; a push into a full queue is ignored.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // Queue state register; reset empties the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
endmodule

module msg_field_extract_mc #(
    parameter int          NUM_CH     = 3,
    parameter int          DATA_BITS  = 264,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] HDR_MAGIC  = 16'h414E,
    parameter int          CNT_BITS   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH*DATA_BITS-1:0] original_data,
    input  logic [NUM_CH-1:0]           message_en_in,
    output logic [NUM_CH-1:0]           in_ready,
    output logic                        message_en_out,
    input  logic                        out_ready,
    output logic [2:0]                  chan_id_out,
    output logic [1:0]                  msg_type_out,
    output logic [DATA_BITS-25:0]       payload_out,
    output logic [CNT_BITS-1:0]         err_cnt,
    output logic [CNT_BITS-1:0]         msg_cnt
);
    logic [NUM_CH-1:0]    fifo_full;
    logic [NUM_CH-1:0]    fifo_empty;
    logic [NUM_CH-1:0]    fifo_push;
    logic [NUM_CH-1:0]    fifo_pop;
    logic [DATA_BITS-1:0] fifo_dout [NUM_CH];

    logic                 grant_vld;
    logic [2:0]           grant_idx;
    logic [DATA_BITS-1:0] gnt_data;
    logic                 load_en;
    logic                 hdr_ok;
    logic [7:0]           type_byte;
    logic [1:0]           dec_type;

    logic                 vld_q, vld_d;
    logic [2:0]           chan_q, chan_d;
    logic [1:0]           type_q, type_d;
    logic [DATA_BITS-25:0] payload_q, payload_d;
    logic [CNT_BITS-1:0]  err_cnt_q, err_cnt_d;
    logic [CNT_BITS-1:0]  msg_cnt_q, msg_cnt_d;
    logic [2:0]           ptr_q, ptr_d;

    assign in_ready = ~fifo_full;
    assign load_en  = (!vld_q || out_ready) && grant_vld;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            assign fifo_push[g] = message_en_in[g] && !fifo_full[g];
            assign fifo_pop[g]  = load_en && (grant_idx == 3'(g));

            msg_fifo #(
                .W     (DATA_BITS),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk       (clk),
                .rst_n     (rst_n),
                .push      (fifo_push[g]),
                .push_data (original_data[g*DATA_BITS +: DATA_BITS]),
                .pop       (fifo_pop[g]),
                .pop_data  (fifo_dout[g]),
                .full      (fifo_full[g]),
                .empty     (fifo_empty[g])
            );
        end
    endgenerate

    // Round-robin pick: first non-empty channel at or after the pointer, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!grant_vld && (i == (int'(ptr_q) + j) % NUM_CH) && !fifo_empty[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = 3'(i);
                end
            end
        end
    end

    // Head entry of the granted channel.
    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_idx == 3'(i)) begin
                gnt_data = fifo_dout[i];
            end
        end
    end

    assign hdr_ok    = (gnt_data[DATA_BITS-1 -: 16] == HDR_MAGIC);
    assign type_byte = gnt_data[DATA_BITS-17 -: 8];

    // Message-type byte decode; unknown types are forwarded as 3.
    always_comb begin
        dec_type = 2'd3;
        if (type_byte == 8'h4E) begin
            dec_type = 2'd1;
        end else if (type_byte == 8'h53) begin
            dec_type = 2'd2;
        end
    end

    // Output stage: load on a free slot, drop bad headers, count handoffs and drops.
    always_comb begin
        vld_d     = vld_q;
        chan_d    = chan_q;
        type_d    = type_q;
        payload_d = payload_q;
        err_cnt_d = err_cnt_q;
        msg_cnt_d = msg_cnt_q;
        ptr_d     = ptr_q;

        if (vld_q && out_ready && (msg_cnt_q != {CNT_BITS{1'b1}})) begin
            msg_cnt_d = msg_cnt_q + CNT_BITS'(1);
        end

        if (load_en) begin
            ptr_d = (grant_idx == 3'(NUM_CH-1)) ? 3'd0 : grant_idx + 3'd1;
            if (hdr_ok) begin
                vld_d     = 1'b1;
                chan_d    = grant_idx;
                type_d    = dec_type;
                payload_d = gnt_data[DATA_BITS-25:0];
            end else begin
                vld_d = 1'b0;
                if (err_cnt_q != {CNT_BITS{1'b1}}) begin
                    err_cnt_d = err_cnt_q + CNT_BITS'(1);
                end
            end
        end else if (out_ready) begin
            vld_d = 1'b0;
        end
    end

    // Output, counter and arbiter-pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= 1'b0;
            chan_q    <= '0;
            type_q    <= '0;
            payload_q <= '0;
            err_cnt_q <= '0;
            msg_cnt_q <= '0;
            ptr_q     <= '0;
        end else begin
            vld_q     <= vld_d;
            chan_q    <= chan_d;
            type_q    <= type_d;
            payload_q <= payload_d;
            err_cnt_q <= err_cnt_d;
            msg_cnt_q <= msg_cnt_d;
            ptr_q     <= ptr_d;
        end
    end

    assign message_en_out = vld_q;
    assign chan_id_out    = chan_q;
    assign msg_type_out   = type_q;
    assign payload_out    = payload_q;
    assign err_cnt        = err_cnt_q;
    assign msg_cnt        = msg_cnt_q;
endmodule

// File: tb/tb_msg_field_extract_mc.sv
// tb/tb_msg_field_extract_mc.sv - table, directed and randomized checks for msg_field_extract_mc
module tb_msg_field_extract_mc;
    localparam int NC    = 3;
    localparam int DW    = 264;
    localparam int PW    = 240;
    localparam int DEPTH = 4;
    localparam int CB    = 5;
    localparam int MAXC  = (1 << CB) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NC*DW-1:0] original_data;
    logic [NC-1:0]    message_en_in;
    logic [NC-1:0]    in_ready;
    logic             message_en_out;
    logic             out_ready;
    logic [2:0]       chan_id_out;
    logic [1:0]       msg_type_out;
    logic [PW-1:0]    payload_out;
    logic [CB-1:0]    err_cnt;
    logic [CB-1:0]    msg_cnt;

    msg_field_extract_mc #(
        .NUM_CH     (NC),
        .DATA_BITS  (DW),
        .FIFO_DEPTH (DEPTH),
        .HDR_MAGIC  (16'h414E),
        .CNT_BITS   (CB)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .original_data  (original_data),
        .message_en_in  (message_en_in),
        .in_ready       (in_ready),
        .message_en_out (message_en_out),
        .out_ready      (out_ready),
        .chan_id_out    (chan_id_out),
        .msg_type_out   (msg_type_out),
        .payload_out    (payload_out),
        .err_cnt        (err_cnt),
        .msg_cnt        (msg_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: per-channel queues plus the visible output register.
    logic [DW-1:0] mq [NC][$];
    int            m_ptr;
    bit            m_vld;
    int            m_chan;
    int            m_type;
    logic [PW-1:0] m_pay;
    int            m_err;
    int            m_msg;

    int            cap_chan [$];
    logic [PW-1:0] cap_pay  [$];

    typedef struct {
        logic [DW-1:0] data;
        logic          exp_vld;
        logic [1:0]    exp_type;
    } vec_t;
    vec_t vt [6];

    task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [15:0] hdr, input logic [7:0] t, input logic [PW-1:0] pay);
        return {hdr, t, pay};
    endfunction

    function automatic logic [PW-1:0] rnd_pay();
        logic [PW-1:0] p;
        for (int w = 0; w < 8; w++) p[w*30 +: 30] = 30'($urandom);
        return p;
    endfunction

    function automatic int type_of(input logic [7:0] t);
        if (t == 8'h4E) return 1;
        if (t == 8'h53) return 2;
        return 3;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NC; i++) mq[i].delete();
        m_ptr = 0; m_vld = 0; m_chan = 0; m_type = 0; m_pay = '0; m_err = 0; m_msg = 0;
    endtask

    task automatic check_all();
        logic [NC-1:0] er;
        for (int i = 0; i < NC; i++) er[i] = (mq[i].size() < DEPTH);
        chk("in_ready", PW'(in_ready), PW'(er));
        chk("valid", PW'(message_en_out), PW'(m_vld));
        chk("chan_id", PW'(chan_id_out), PW'(m_chan));
        chk("msg_type", PW'(msg_type_out), PW'(m_type));
        chk("payload", payload_out, m_pay);
        chk("err_cnt", PW'(err_cnt), PW'(m_err));
        chk("msg_cnt", PW'(msg_cnt), PW'(m_msg));
    endtask

    // One clock: advance the model on the rising edge, compare on the falling edge.
    task automatic step();
        bit            rdy_pre [NC];
        logic [DW-1:0] d;
        int            k;
        @(posedge clk);
        for (int i = 0; i < NC; i++) rdy_pre[i] = (mq[i].size() < DEPTH);
        if (m_vld && out_ready && m_msg < MAXC) m_msg++;
        k = -1;
        for (int j = 0; j < NC; j++) begin
            int c;
            c = (m_ptr + j) % NC;
            if (k < 0 && mq[c].size() > 0) k = c;
        end
        if ((!m_vld || out_ready) && k >= 0) begin
            d = mq[k].pop_front();
            m_ptr = (k + 1) % NC;
            if (d[DW-1 -: 16] == 16'h414E) begin
                m_vld = 1; m_chan = k; m_type = type_of(d[DW-17 -: 8]); m_pay = d[PW-1:0];
            end else begin
                m_vld = 0;
                if (m_err < MAXC) m_err++;
            end
        end else if (out_ready) begin
            m_vld = 0;
        end
        for (int i = 0; i < NC; i++)
            if (message_en_in[i] && rdy_pre[i]) mq[i].push_back(original_data[i*DW +: DW]);
        @(negedge clk);
        check_all();
    endtask

    task automatic set_ch(input int i, input logic en, input logic [DW-1:0] d);
        message_en_in[i] = en;
        original_data[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        message_en_in = '0;
        out_ready = 1'b1;
        model_clear();
        @(negedge clk);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int            sent;
        bit            rdy;
        logic          en;
        logic [DW-1:0] seq [3];

        vt[0] = '{{24'h414E4E, 32'hFFFFFFFF, 32'h0F0F0F0F, 176'h0}, 1'b1, 2'd1};
        vt[1] = '{mk(16'h414E, 8'h53, {60{4'h5}}), 1'b1, 2'd2};
        vt[2] = '{mk(16'h414E, 8'h00, 240'h1234), 1'b1, 2'd3};
        vt[3] = '{mk(16'h414E, 8'hFF, 240'hABCD), 1'b1, 2'd3};
        vt[4] = '{mk(16'h414E, 8'h4F, 240'h77), 1'b1, 2'd3};
        vt[5] = '{mk(16'h414F, 8'h4E, 240'h99), 1'b0, 2'd0};

        rst_n = 1'b0;
        message_en_in = '0;
        original_data = '0;
        out_ready = 1'b1;
        model_clear();
        repeat (5) @(negedge clk);
        check_all();
        chk("reset_in_ready", PW'(in_ready), PW'(3'b111));
        repeat (5) @(negedge clk);
        rst_n = 1'b1;

        // Table: one message on channel 0 per entry.
        for (int i = 0; i < 6; i++) begin
            set_ch(0, 1'b1, vt[i].data);
            step();
            message_en_in = '0;
            step();
            chk("tbl_valid", PW'(message_en_out), PW'(vt[i].exp_vld));
            if (vt[i].exp_vld) begin
                chk("tbl_type", PW'(msg_type_out), PW'(vt[i].exp_type));
                chk("tbl_chan", PW'(chan_id_out), PW'(0));
                chk("tbl_payload", payload_out, vt[i].data[PW-1:0]);
            end
            if (i == 0) chk("tbl_payload_hi", PW'(payload_out[239:208]), PW'(32'hFFFFFFFF));
            step();
            if (i == 0) chk("tbl_first_msg_cnt", PW'(msg_cnt), PW'(1));
        end
        chk("tbl_err_cnt", PW'(err_cnt), PW'(1));

        // Simultaneous arrival on all three channels.
        do_reset();
        set_ch(0, 1'b1, mk(16'h414E, 8'h4E, 240'hA0));
        set_ch(1, 1'b1, mk(16'h414E, 8'h53, {60{4'h5}}));
        set_ch(2, 1'b1, mk(16'h414E, 8'h4E, 240'hC0));
        step();
        message_en_in = '0;
        step();
        chk("sim_chan0", PW'(chan_id_out), PW'(0));
        chk("sim_type0", PW'(msg_type_out), PW'(1));
        step();
        chk("sim_chan1", PW'(chan_id_out), PW'(1));
        chk("sim_type1", PW'(msg_type_out), PW'(2));
        step();
        chk("sim_chan2", PW'(chan_id_out), PW'(2));
        chk("sim_type2", PW'(msg_type_out), PW'(1));
        step();
        set_ch(0, 1'b1, mk(16'h414E, 8'h4E, 240'hA1));
        set_ch(1, 1'b1, mk(16'h414E, 8'h4E, 240'hB1));
        step();
        message_en_in = '0;
        step();
        chk("ptr_wrap_chan", PW'(chan_id_out), PW'(0));
        repeat (3) step();

        // Backpressure on channel 1 with a producer that holds until accepted.
        do_reset();
        out_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 10; c++) begin
            rdy = in_ready[1];
            en = (sent < 6);
            set_ch(1, en, mk(16'h414E, 8'h4E, PW'(sent + 100)));
            step();
            if (en && rdy) sent++;
        end
        chk("bp_accepted", PW'(sent), PW'(5));
        chk("bp_in_ready", PW'(in_ready[1]), PW'(0));
        chk("bp_hold_payload", payload_out, PW'(100));
        out_ready = 1'b1;
        cap_pay.delete();
        for (int c = 0; c < 30 && cap_pay.size() < 6; c++) begin
            if (message_en_out) cap_pay.push_back(payload_out);
            rdy = in_ready[1];
            en = (sent < 6);
            set_ch(1, en, mk(16'h414E, 8'h4E, PW'(sent + 100)));
            step();
            if (en && rdy) sent++;
        end
        chk("bp_count", PW'(cap_pay.size()), PW'(6));
        for (int j = 0; j < cap_pay.size() && j < 6; j++) chk("bp_order", cap_pay[j], PW'(j + 100));

        // Bad header between two good messages on channel 2.
        do_reset();
        seq[0] = mk(16'h414E, 8'h4E, 240'h1111);
        seq[1] = '0;
        seq[2] = mk(16'h414E, 8'h53, 240'h2222);
        cap_pay.delete();
        for (int c = 0; c < 10; c++) begin
            if (message_en_out) cap_pay.push_back(payload_out);
            if (c < 3) set_ch(2, 1'b1, seq[c]);
            else message_en_in = '0;
            step();
        end
        chk("bad_err_cnt", PW'(err_cnt), PW'(1));
        chk("bad_count", PW'(cap_pay.size()), PW'(2));
        if (cap_pay.size() == 2) begin
            chk("bad_first", cap_pay[0], PW'(240'h1111));
            chk("bad_second", cap_pay[1], PW'(240'h2222));
        end

        // Fairness between two continuously valid channels.
        do_reset();
        cap_chan.delete();
        set_ch(0, 1'b1, mk(16'h414E, 8'h4E, 240'h10));
        set_ch(2, 1'b1, mk(16'h414E, 8'h53, 240'h20));
        for (int c = 0; c < 14; c++) begin
            if (message_en_out) cap_chan.push_back(int'(chan_id_out));
            if (c == 12) message_en_in = '0;
            step();
        end
        chk("fair_count", PW'(cap_chan.size() >= 10), PW'(1));
        for (int j = 0; j < cap_chan.size() && j < 10; j++) chk("fair_grant", PW'(cap_chan[j]), PW'((j % 2) * 2));

        // Reset pulse while queues are partially full and the output is valid.
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < NC; i++) set_ch(i, 1'b1, mk(16'h414E, 8'h4E, PW'(c * 16 + i)));
            step();
        end
        chk("pre_reset_valid", PW'(message_en_out), PW'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", PW'(message_en_out), PW'(0));
        chk("rst_msg_cnt", PW'(msg_cnt), PW'(0));
        chk("rst_err_cnt", PW'(err_cnt), PW'(0));
        chk("rst_in_ready", PW'(in_ready), PW'(3'b111));
        chk("rst_payload", payload_out, PW'(0));
        model_clear();
        message_en_in = '0;
        out_ready = 1'b1;
        #9;
        rst_n = 1'b1;
        for (int i = 0; i < NC; i++) set_ch(i, 1'b1, mk(16'h414E, 8'h53, PW'(i + 50)));
        step();
        message_en_in = '0;
        step();
        chk("post_rst_valid", PW'(message_en_out), PW'(1));
        chk("post_rst_chan", PW'(chan_id_out), PW'(0));
        repeat (3) step();

        // Randomized traffic against the model; long enough to saturate both counters.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NC; i++) begin
                logic [15:0] hdr;
                logic [7:0]  t;
                int          r;
                hdr = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h414E;
                r = $urandom_range(0, 2);
                t = (r == 0) ? 8'h4E : (r == 1) ? 8'h53 : 8'($urandom);
                set_ch(i, 1'($urandom), mk(hdr, t, rnd_pay()));
            end
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        message_en_in = '0;
        out_ready = 1'b1;
        repeat (20) step();
        chk("sat_msg_cnt", PW'(msg_cnt), PW'(MAXC));
        chk("sat_err_cnt", PW'(err_cnt), PW'(MAXC));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
